hazard_ctrl_unit: RTL and testbench

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/fwd_sel.sv | 36 +++
 rtl/hazard_ctrl_unit.sv | 138 +++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hazard_pkg
// Brief   : Shared encodings for PC source and operand-forward selects.
// Rev     : 1.0  initial release
// ============================================================================
package hazard_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_JR  = 2'b10,
        PCSRC_J   = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    localparam int c_flush_cnt_w = 3;

endpackage
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// ============================================================================
// Module  : fwd_sel
// Brief   : Picks the operand source for one EX read port (MEM beats WB).
// Rev     : 1.0  initial release
// ============================================================================
module fwd_sel #(
    parameter int REG_AW = 2
) (
    input  logic              use_src,
    input  logic [REG_AW-1:0] src,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] mem_wreg,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] wb_wreg,
    output logic [1:0]        sel
);
    import hazard_pkg::*;

    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = use_src && mem_regwrite && (src == mem_wreg);
    assign w_wb_hit  = use_src && wb_regwrite  && (src == wb_wreg);

    always_comb begin
        sel = FWD_RF;
        if (w_mem_hit) begin
            sel = FWD_MEM;
        end else if (w_wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module  : hazard_ctrl_unit
// Brief   : Load-use stall, redirect flush sequencing and operand forwarding.
//           Optional macro HAZARD_PERF_CNT_EN adds stall/flush event counters.
// Rev     : 1.0  initial release
// ============================================================================
module hazard_ctrl_unit #(
    parameter int REG_AW       = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_wreg,
    input  logic              ex_use_rs,
    input  logic              ex_use_rt,
    input  logic              br_taken,
    input  logic              ex_is_jr,
    input  logic              ex_is_j,
    input  logic              mem_regwrite,
    input  logic              wb_regwrite,
    input  logic [REG_AW-1:0] mem_wreg,
    input  logic [REG_AW-1:0] wb_wreg,
    input  logic              halted,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              flush_busy,
    output logic [1:0]        pc_src,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);
    import hazard_pkg::*;

    localparam logic [c_flush_cnt_w-1:0] c_flush_load = c_flush_cnt_w'(FLUSH_CYCLES);

    logic                     w_load_use;
    logic                     w_redirect;
    logic                     w_flush_busy;
    logic                     w_idex_bubble;
    logic [c_flush_cnt_w-1:0] r_flush_ctr;

    assign w_load_use = ex_valid && ex_is_load &&
                        ((id_use_rs && (id_rs == ex_wreg)) ||
                         (id_use_rt && (id_rt == ex_wreg)));

    assign w_redirect = ex_valid && (br_taken || ex_is_jr || ex_is_j);

    // Counter-derived terms are masked while reset is held so they read 0.
    assign w_flush_busy  = reset_n && (r_flush_ctr != '0);
    assign w_idex_bubble = w_load_use || w_redirect || w_flush_busy;

    assign pc_write    = !halted && !w_load_use;
    assign ifid_write  = !halted && !w_load_use;
    assign idex_bubble = w_idex_bubble;
    assign flush_busy  = w_flush_busy;

    always_comb begin
        pc_src = PCSRC_SEQ;
        if (ex_valid) begin
            if (br_taken) begin
                pc_src = PCSRC_BR;
            end else if (ex_is_jr) begin
                pc_src = PCSRC_JR;
            end else if (ex_is_j) begin
                pc_src = PCSRC_J;
            end
        end
    end

    // A new redirect always restarts the drain, even mid-sequence.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_flush_ctr <= '0;
        end else if (w_redirect) begin
            r_flush_ctr <= c_flush_load;
        end else if (r_flush_ctr != '0) begin
            r_flush_ctr <= r_flush_ctr - 1'b1;
        end
    end

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .use_src      (ex_use_rs),
        .src          (ex_rs),
        .mem_regwrite (mem_regwrite),
        .mem_wreg     (mem_wreg),
        .wb_regwrite  (wb_regwrite),
        .wb_wreg      (wb_wreg),
        .sel          (fwd_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .use_src      (ex_use_rt),
        .src          (ex_rt),
        .mem_regwrite (mem_regwrite),
        .mem_wreg     (mem_wreg),
        .wb_regwrite  (wb_regwrite),
        .wb_wreg      (wb_wreg),
        .sel          (fwd_b)
    );

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_load_use) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_idex_bubble && !w_load_use) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_ctrl_unit
// Brief   : Directed self-checking bench for hazard_ctrl_unit (REG_AW=2,
//           FLUSH_CYCLES=2); perf counters exercised when HAZARD_PERF_CNT_EN.
// Rev     : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl_unit;

    localparam int REG_AW       = 2;
    localparam int FLUSH_CYCLES = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [REG_AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
    logic              id_use_rs, id_use_rt, ex_valid, ex_is_load;
    logic              ex_use_rs, ex_use_rt, br_taken, ex_is_jr, ex_is_j;
    logic              mem_regwrite, wb_regwrite, halted;
    logic              pc_write, ifid_write, idex_bubble, flush_busy;
    logic [1:0]        pc_src, fwd_a, fwd_b;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0]       stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(.REG_AW(REG_AW), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .ex_valid     (ex_valid),
        .ex_is_load   (ex_is_load),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_wreg      (ex_wreg),
        .ex_use_rs    (ex_use_rs),
        .ex_use_rt    (ex_use_rt),
        .br_taken     (br_taken),
        .ex_is_jr     (ex_is_jr),
        .ex_is_j      (ex_is_j),
        .mem_regwrite (mem_regwrite),
        .wb_regwrite  (wb_regwrite),
        .mem_wreg     (mem_wreg),
        .wb_wreg      (wb_wreg),
        .halted       (halted),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_bubble  (idex_bubble),
        .flush_busy   (flush_busy),
        .pc_src       (pc_src),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_rs = '0; ex_rt = '0; ex_wreg = '0;
        ex_use_rs = 1'b0; ex_use_rt = 1'b0; br_taken = 1'b0; ex_is_jr = 1'b0;
        ex_is_j = 1'b0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
        mem_wreg = '0; wb_wreg = '0; halted = 1'b0;
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Flush-state snapshot: bubble, busy, pc_src.
    task automatic chk_flush(input string tag, input logic bub, input logic busy, input logic [1:0] src);
        #2;
        chk({tag, ".bubble"}, 32'(idex_bubble), 32'(bub));
        chk({tag, ".busy"},   32'(flush_busy),  32'(busy));
        chk({tag, ".pc_src"}, 32'(pc_src),      32'(src));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        idle();
        next();
        next();
        #2;
        chk("rst.pc_write",   32'(pc_write),    32'd1);
        chk("rst.ifid_write", 32'(ifid_write),  32'd1);
        chk("rst.bubble",     32'(idex_bubble), 32'd0);
        chk("rst.busy",       32'(flush_busy),  32'd0);
        chk("rst.pc_src",     32'(pc_src),      32'd0);
        chk("rst.fwd_a",      32'(fwd_a),       32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("rst.stall_cnt",  stall_cnt,        32'd0);
        chk("rst.flush_cnt",  flush_cnt,        32'd0);
`endif
        reset_n = 1'b1;
        next();

        // Load-use on rs: stall for exactly the cycle the load sits in EX
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_wreg = 2'd2;
        id_rs = 2'd2; id_use_rs = 1'b1;
        #2;
        chk("lu_rs.pc_write",   32'(pc_write),    32'd0);
        chk("lu_rs.ifid_write", 32'(ifid_write),  32'd0);
        chk("lu_rs.bubble",     32'(idex_bubble), 32'd1);
        chk("lu_rs.pc_src",     32'(pc_src),      32'd0);
        next();
        ex_valid = 1'b0;
        #2;
        chk("lu_inv.pc_write", 32'(pc_write),    32'd1);
        chk("lu_inv.bubble",   32'(idex_bubble), 32'd0);
        chk("lu_inv.busy",     32'(flush_busy),  32'd0);
        next();
        ex_valid = 1'b1; id_use_rs = 1'b0; id_rt = 2'd2; id_use_rt = 1'b1; id_rs = 2'd1;
        #2;
        chk("lu_rt.pc_write", 32'(pc_write), 32'd0);
        id_use_rt = 1'b0;
        #1;
        chk("lu_nouse.pc_write", 32'(pc_write), 32'd1);
        ex_is_load = 1'b0; id_use_rt = 1'b1;
        #1;
        chk("lu_noload.bubble", 32'(idex_bubble), 32'd0);
        idle();
        halted = 1'b1;
        #1;
        chk("halt.pc_write",   32'(pc_write),   32'd0);
        chk("halt.ifid_write", 32'(ifid_write), 32'd0);
        chk("halt.bubble",     32'(idex_bubble), 32'd0);
        next();

        // Taken branch: one redirect bubble then FLUSH_CYCLES busy bubbles
        idle();
        ex_valid = 1'b1; br_taken = 1'b1;
        chk_flush("br.c1", 1'b1, 1'b0, 2'b01);
        next();
        idle();
        chk_flush("br.c2", 1'b1, 1'b1, 2'b00);
        next();
        chk_flush("br.c3", 1'b1, 1'b1, 2'b00);
        next();
        chk_flush("br.c4", 1'b0, 1'b0, 2'b00);

        // pc_src priority and ex_valid qualification (combinational only)
        ex_valid = 1'b1; br_taken = 1'b1; ex_is_jr = 1'b1; ex_is_j = 1'b1;
        #1;
        chk("prio.br", 32'(pc_src), 32'd1);
        br_taken = 1'b0;
        #1;
        chk("prio.jr", 32'(pc_src), 32'd2);
        ex_is_jr = 1'b0;
        #1;
        chk("prio.j", 32'(pc_src), 32'd3);
        ex_valid = 1'b0;
        #1;
        chk("prio.inv.src",    32'(pc_src),      32'd0);
        chk("prio.inv.bubble", 32'(idex_bubble), 32'd0);
        idle();
        next();
        #2;
        chk("prio.inv.busy", 32'(flush_busy), 32'd0);

        // Second redirect one cycle into the flush reloads the counter
        next();
        ex_valid = 1'b1; br_taken = 1'b1;
        chk_flush("rr.c1", 1'b1, 1'b0, 2'b01);
        next();
        br_taken = 1'b0; ex_is_j = 1'b1;
        chk_flush("rr.c2", 1'b1, 1'b1, 2'b11);
        next();
        idle();
        chk_flush("rr.c3", 1'b1, 1'b1, 2'b00);
        next();
        chk_flush("rr.c4", 1'b1, 1'b1, 2'b00);
        next();
        chk_flush("rr.c5", 1'b0, 1'b0, 2'b00);

        // Halt does not freeze the drain
        ex_valid = 1'b1; ex_is_jr = 1'b1;
        chk_flush("hd.c1", 1'b1, 1'b0, 2'b10);
        next();
        idle();
        halted = 1'b1;
        chk_flush("hd.c2", 1'b1, 1'b1, 2'b00);
        chk("hd.c2.pc_write", 32'(pc_write), 32'd0);
        next();
        chk_flush("hd.c3", 1'b1, 1'b1, 2'b00);
        next();
        chk_flush("hd.c4", 1'b0, 1'b0, 2'b00);
        halted = 1'b0;

        // Reset while counter=2 aborts the flush
        ex_valid = 1'b1; br_taken = 1'b1;
        next();
        idle();
        #2;
        chk("rmf.busy_before", 32'(flush_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rmf.busy_in_rst", 32'(flush_busy), 32'd0);
        chk("rmf.pc_write",    32'(pc_write),   32'd1);
        next();
        reset_n = 1'b1;
        #2;
        chk("rmf.busy_after",   32'(flush_busy),  32'd0);
        chk("rmf.bubble_after", 32'(idex_bubble), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        chk("rmf.stall_cnt", stall_cnt, 32'd0);
        chk("rmf.flush_cnt", flush_cnt, 32'd0);
`endif

        // Forwarding: MEM over WB, qualified by use, independent of ex_valid
        ex_rs = 2'd1; mem_wreg = 2'd1; wb_wreg = 2'd1;
        mem_regwrite = 1'b1; wb_regwrite = 1'b1; ex_use_rs = 1'b1;
        #1;
        chk("fwd_a.mem", 32'(fwd_a), 32'd2);
        mem_regwrite = 1'b0;
        #1;
        chk("fwd_a.wb", 32'(fwd_a), 32'd1);
        ex_use_rs = 1'b0;
        #1;
        chk("fwd_a.nouse", 32'(fwd_a), 32'd0);
        ex_rt = 2'd3; ex_use_rt = 1'b1; mem_regwrite = 1'b1; mem_wreg = 2'd3; wb_wreg = 2'd3;
        #1;
        chk("fwd_b.mem", 32'(fwd_b), 32'd2);
        chk("fwd_b.a_rf", 32'(fwd_a), 32'd0);
        mem_wreg = 2'd2;
        #1;
        chk("fwd_b.wb", 32'(fwd_b), 32'd1);
        wb_regwrite = 1'b0;
        #1;
        chk("fwd_b.rf", 32'(fwd_b), 32'd0);
        idle();
        next();

        // Perf scenario: three stalls, then one redirect with its drain
        for (int i = 0; i < 3; i++) begin
            ex_valid = 1'b1; ex_is_load = 1'b1; ex_wreg = 2'd3;
            id_rs = 2'd3; id_use_rs = 1'b1;
            next();
            idle();
            next();
        end
        ex_valid = 1'b1; br_taken = 1'b1;
        next();
        idle();
        next();
        next();
        next();
        chk_flush("perf.drained", 1'b0, 1'b0, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf.stall_cnt", stall_cnt, 32'd3);
        chk("perf.flush_cnt", flush_cnt, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
